dec_counter_ctrl: RTL and testbench
===================================

# dec_counter_ctrl

Run/stop/clear controller for a cascaded multi-digit decimal (BCD) counter, acting as the sequencer for the team's decade-counter datapath. It accepts single-cycle commands from a host over a valid/ready handshake and generates the per-digit count enables and ripple carries. It also maintains a frozen "lap" display copy and reports wrap-around. The block sits between the control/host logic and the digit display path.

## Interface
- DIGITS, 4: number of decade digits, legal range 1–8.
- TICK_DIV, 1: number of RUN clock cycles per count increment, legal range 1–65535.
- clk  in  1: single clock; all state updates on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- cmd_valid  in  1: host command strobe.
- cmd  in  2: command code.
  - 00 START
  - 01 STOP
  - 10 CLEAR
  - 11 LAP
- cmd_ready  out  1: command accepted on an edge where cmd_valid && cmd_ready.
- count  out  4*DIGITS: live BCD value; digit 0 is [3:0].
- display  out  4*DIGITS: value presented to the display.
- running  out  1: high in RUN or LAP.
- ovf  out  1: sticky wrap flag.
- state  out  3: FSM state code.

## Operation
- States, encoded in the package:
  - IDLE=0
  - RUN=1
  - PAUSE=2
  - LAP=3
  - CLR=4
- Reset values: state IDLE, count 0, display 0, prescaler 0, ovf 0, running 0, cmd_ready 1.
- Transitions on an accepted command:
  - IDLE: START→RUN.
  - RUN: STOP→PAUSE; LAP→LAP.
  - PAUSE: START→RUN, resuming with the prescaler value retained.
  - LAP: LAP→RUN; STOP→PAUSE, and display resumes following count.
  - CLEAR in any non-CLR state→CLR.
  - CLR→IDLE unconditionally after one cycle.
  - All other state/command pairs are accepted and ignored, with no state change.
- cmd_ready is 0 only in CLR; it is 1 in every other state.
- Prescaler: counts 0..TICK_DIV-1 only in RUN and LAP, and wraps to 0. tick = running && prescaler==TICK_DIV-1.
- Digit chain: digit 0 is enabled on tick. Digit k is enabled when tick is high and digits 0..k-1 all equal 9. An enabled digit at 9 goes to 0; otherwise it increments by 1.
- Wrap: when all digits are 9 and tick is high, count becomes 0 and ovf is set to 1. ovf stays at 1 until CLEAR or reset.
- display:
  - Equals count in every state except LAP.
  - On the edge that accepts LAP from RUN, the display register captures the post-edge count, including any increment on that same edge.
  - The captured value is held while in LAP.
- CLEAR: count, prescaler and ovf are zeroed on the accepting edge.

## Timing
- Command latency: a command accepted at edge N changes state at edge N, visible after N.
- START at edge N with prescaler 0 gives the first increment at edge N+TICK_DIV.
- Tick and STOP on the same edge: the increment is applied and the state becomes PAUSE.
- Tick and LAP on the same edge: the increment is applied and the captured value includes it.
- Tick and CLEAR on the same edge: CLEAR wins; count is 0.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronous). Operation resumes on the first clock edge after rst_n deasserts.
- Ignored commands never stall the handshake.

## Configuration
- DEC_CTRL_LAP_EN:
  - Defined: the LAP state and display capture register are present, as described above.
  - Undefined:
    - cmd 11 is accepted and ignored.
    - The LAP state is unreachable, and display is wired directly to count.
    - state never reports 3.

## Structure
- Package dec_ctrl_pkg holds:
  - state encoding constants/typedef;
  - command code constants (CMD_START, CMD_STOP, CMD_CLEAR, CMD_LAP);
  - BCD_MAX = 4'd9.
- Sub-module m_dec_digit: one decade digit, instantiated DIGITS times in a generate loop.
  - Inputs: clk, rst_n, clr, en.
  - Outputs: q[3:0], and at9 = (q==9).
- The top level holds the FSM, prescaler, carry-enable chain, display register and ovf.

## Test plan
- Reset: hold rst_n=0 with clk running → count=0, display=0, ovf=0, state=IDLE, cmd_ready=1. Asserting rst_n mid-RUN at count 0x0042 → immediate return to all zeros.
- DIGITS=4, TICK_DIV=1: START, then 15 clocks → count=0x0015. STOP → count holds 0x0015 for 10 cycles. START → counting resumes, reaching 0x0016 one edge later.
- Run to count=0x9999, then one tick → count=0x0000, ovf=1. Continue 3 ticks → count=0x0003, ovf still 1. CLEAR → ovf=0, cmd_ready=0 for one cycle, then state IDLE.
- TICK_DIV=3: START → increments occur every 3 edges. STOP at prescaler=1, then START → next increment arrives 2 edges after resume.
- With DEC_CTRL_LAP_EN: LAP at count=0x0020 → display holds 0x0020 while count advances to 0x0030. LAP again → display=count. Without the macro, the same stimulus gives display==count throughout.
- CLEAR and tick on the same edge in RUN at count 0x0099 → count=0x0000 and no ovf. An ignored STOP in IDLE → no state change, cmd_ready stays 1.

Source files
------------

// File: rtl/dec_ctrl_pkg.sv
// dec_ctrl_pkg: shared definitions for the decade-counter sequencer.
//   - state_t    : FSM state encoding (also reported on the state port)
//   - CMD_*      : host command codes
//   - BCD_MAX    : largest legal value of one decade digit
package dec_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_CLR   = 3'd4
  } state_t;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b10;
  localparam logic [1:0] CMD_LAP   = 2'b11;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/m_dec_digit.sv
// m_dec_digit: one decade (BCD) digit, 0..9, wrapping to 0 after 9.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count enable for this digit
//   q          : digit value
//   at9        : high when q == 9 (feeds the carry chain)
module m_dec_digit
  import dec_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       at9
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (en) begin
      q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end
  end

  assign at9 = (q == BCD_MAX);

endmodule

// File: rtl/dec_counter_ctrl.sv
// dec_counter_ctrl: run/stop/clear/lap sequencer for a cascaded BCD counter.
// Parameters: DIGITS (1..8 decade digits), TICK_DIV (RUN cycles per count).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd_valid, cmd[1:0] : host command (START/STOP/CLEAR/LAP)
//   cmd_ready           : high in every state except CLR
//   count               : live BCD value, digit 0 in [3:0]
//   display             : count, or the frozen lap copy while in LAP
//   running             : high in RUN or LAP
//   ovf                 : sticky wrap flag, cleared by CLEAR or reset
//   state               : FSM state code (dec_ctrl_pkg::state_t)
// Build option: define DEC_CTRL_LAP_EN to include the LAP state and the
// display capture register; otherwise LAP is ignored and display == count.
module dec_counter_ctrl
  import dec_ctrl_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd,
  output logic                  cmd_ready,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   display,
  output logic                  running,
  output logic                  ovf,
  output logic [2:0]            state
);

  localparam int W = 4 * DIGITS;
  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  // Handshake: a command is taken on every rising edge where
  // cmd_valid && cmd_ready. Every command is consumed when taken, even if it
  // has no effect in the current state; cmd_ready drops only for the single
  // CLR cycle.
  logic   accept;
  state_t st, st_nxt;
  logic [15:0] presc;
  logic   tick;
  logic   clr;
  logic [DIGITS-1:0] at9;
  logic [DIGITS-1:0] en;
  logic [DIGITS:0]   all9;
  logic   wrap;

  assign accept = cmd_valid && cmd_ready;
  assign clr    = accept && (cmd == CMD_CLEAR);
  assign tick   = running && (presc == PRESC_LAST);

  // Ripple carry: digit k counts when every lower digit is at 9.
  assign all9[0] = 1'b1;
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign all9[k+1] = all9[k] & at9[k];
    assign en[k]     = tick & all9[k] & ~clr;

    m_dec_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .en    (en[k]),
      .q     (count[4*k +: 4]),
      .at9   (at9[k])
    );
  end

  assign wrap = tick & all9[DIGITS];

  always_comb begin
    st_nxt = st;
    if (st == ST_CLR) begin
      st_nxt = ST_IDLE;
    end else if (accept) begin
      if (cmd == CMD_CLEAR) begin
        st_nxt = ST_CLR;
      end else begin
        case (st)
          ST_IDLE:  if (cmd == CMD_START) st_nxt = ST_RUN;
          ST_RUN: begin
            if (cmd == CMD_STOP) st_nxt = ST_PAUSE;
`ifdef DEC_CTRL_LAP_EN
            else if (cmd == CMD_LAP) st_nxt = ST_LAP;
`endif
          end
          ST_PAUSE: if (cmd == CMD_START) st_nxt = ST_RUN;
`ifdef DEC_CTRL_LAP_EN
          ST_LAP: begin
            if (cmd == CMD_LAP) st_nxt = ST_RUN;
            else if (cmd == CMD_STOP) st_nxt = ST_PAUSE;
          end
`endif
          default: st_nxt = st;
        endcase
      end
    end
  end

  // State plus registered status outputs; the prescaler keeps its value in
  // PAUSE so a resumed run finishes the partial tick period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      running   <= 1'b0;
      cmd_ready <= 1'b1;
      presc     <= 16'd0;
      ovf       <= 1'b0;
    end else begin
      st        <= st_nxt;
      running   <= (st_nxt == ST_RUN) || (st_nxt == ST_LAP);
      cmd_ready <= (st_nxt != ST_CLR);
      if (clr)          presc <= 16'd0;
      else if (running) presc <= tick ? 16'd0 : presc + 16'd1;
      if (clr)          ovf <= 1'b0;
      else if (wrap)    ovf <= 1'b1;
    end
  end

  assign state = st;

`ifdef DEC_CTRL_LAP_EN
  // The lap copy must include an increment landing on the capture edge, so
  // it loads the post-edge value of the digit chain.
  logic [W-1:0] count_nxt;
  logic [W-1:0] lap_q;

  always_comb begin
    count_nxt = count;
    for (int k = 0; k < DIGITS; k++) begin
      if (clr)        count_nxt[4*k +: 4] = 4'd0;
      else if (en[k]) count_nxt[4*k +: 4] = at9[k] ? 4'd0 : count[4*k +: 4] + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q <= '0;
    end else if (accept && (st == ST_RUN) && (cmd == CMD_LAP)) begin
      lap_q <= count_nxt;
    end
  end

  assign display = (st == ST_LAP) ? lap_q : count;
`else
  assign display = count;
`endif

endmodule

// File: tb/tb_dec_counter_ctrl.sv
// Directed bench for dec_counter_ctrl: instance a uses TICK_DIV=1,
// instance b uses TICK_DIV=3. Inputs change on the falling edge, outputs
// are checked on the falling edge after each rising edge.
module tb_dec_counter_ctrl;

  localparam int W = 16;
`ifdef DEC_CTRL_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         cmd_valid_a = 1'b0, cmd_valid_b = 1'b0;
  logic [1:0]   cmd_a = 2'b00, cmd_b = 2'b00;
  logic         cmd_ready_a, cmd_ready_b;
  logic [W-1:0] count_a, count_b, display_a, display_b;
  logic         running_a, running_b, ovf_a, ovf_b;
  logic [2:0]   state_a, state_b;

  dec_counter_ctrl #(.DIGITS(4), .TICK_DIV(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_a), .cmd(cmd_a),
    .cmd_ready(cmd_ready_a), .count(count_a), .display(display_a),
    .running(running_a), .ovf(ovf_a), .state(state_a)
  );

  dec_counter_ctrl #(.DIGITS(4), .TICK_DIV(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_b), .cmd(cmd_b),
    .cmd_ready(cmd_ready_b), .count(count_b), .display(display_b),
    .running(running_b), .ovf(ovf_b), .state(state_b)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drivers (called at a falling edge, return at a falling edge)
  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_a(input logic [1:0] c);
    cmd_valid_a = 1'b1;
    cmd_a = c;
    @(negedge clk);
    cmd_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] c);
    cmd_valid_b = 1'b1;
    cmd_b = c;
    @(negedge clk);
    cmd_valid_b = 1'b0;
  endtask

  localparam logic [1:0] START = 2'b00, STOP = 2'b01, CLEAR = 2'b10, LAP = 2'b11;

  initial begin
    // reset held with clock running
    clocks(3);
    check("rst_count", count_a, 0);
    check("rst_display", display_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_state", state_a, 0);
    check("rst_ready", cmd_ready_a, 1);
    check("rst_running", running_a, 0);
    check("rst_b_state", state_b, 0);
    rst_n = 1'b1;
    clocks(1);

    // ignored STOP in IDLE
    send_a(STOP);
    check("idle_stop_state", state_a, 0);
    check("idle_stop_ready", cmd_ready_a, 1);

    // START, count to 15 (the STOP edge carries the 15th tick)
    send_a(START);
    check("start_state", state_a, 1);
    check("start_running", running_a, 1);
    check("start_count", count_a, 16'h0000);
    clocks(14);
    check("run14", count_a, 16'h0014);
    send_a(STOP);
    check("stop_count", count_a, 16'h0015);
    check("stop_state", state_a, 2);
    clocks(10);
    check("pause_hold", count_a, 16'h0015);
    check("pause_running", running_a, 0);
    send_a(START);
    check("resume_edge", count_a, 16'h0015);
    clocks(1);
    check("resume_plus1", count_a, 16'h0016);

    // run to 9999 then wrap
    clocks(9999 - 16);
    check("at_9999", count_a, 16'h9999);
    check("ovf_before", ovf_a, 0);
    clocks(1);
    check("wrap_count", count_a, 16'h0000);
    check("wrap_ovf", ovf_a, 1);
    clocks(3);
    check("post_wrap_count", count_a, 16'h0003);
    check("post_wrap_ovf", ovf_a, 1);
    send_a(CLEAR);
    check("clr_ovf", ovf_a, 0);
    check("clr_count", count_a, 0);
    check("clr_state", state_a, 4);
    check("clr_ready", cmd_ready_a, 0);
    clocks(1);
    check("clr_idle", state_a, 0);
    check("clr_ready_back", cmd_ready_a, 1);

    // lap capture, tick on the capture edge
    send_a(START);
    clocks(19);
    check("lap_pre", count_a, 16'h0019);
    send_a(LAP);
    check("lap_count", count_a, 16'h0020);
    check("lap_display", display_a, 16'h0020);
    check("lap_state", state_a, LAP_EN ? 3 : 1);
    check("lap_running", running_a, 1);
    clocks(10);
    check("lap_count_adv", count_a, 16'h0030);
    check("lap_display_hold", display_a, LAP_EN ? 16'h0020 : 16'h0030);
    send_a(LAP);
    check("lap2_state", state_a, 1);
    check("lap2_count", count_a, 16'h0031);
    check("lap2_display", display_a, 16'h0031);

    // async reset mid-RUN at 0042
    clocks(11);
    check("pre_rst", count_a, 16'h0042);
    rst_n = 1'b0;
    #1;
    check("async_count", count_a, 0);
    check("async_display", display_a, 0);
    check("async_state", state_a, 0);
    check("async_running", running_a, 0);
    check("async_ready", cmd_ready_a, 1);
    clocks(2);
    rst_n = 1'b1;
    clocks(1);

    // CLEAR and tick on the same edge at 0099
    send_a(START);
    clocks(99);
    check("at_0099", count_a, 16'h0099);
    send_a(CLEAR);
    check("clr_tick_count", count_a, 0);
    check("clr_tick_ovf", ovf_a, 0);
    check("clr_tick_state", state_a, 4);

    // TICK_DIV=3 instance
    send_b(START);
    check("b_start", count_b, 0);
    clocks(2);
    check("b_two", count_b, 0);
    clocks(1);
    check("b_three", count_b, 1);
    send_b(STOP);
    check("b_stop_state", state_b, 2);
    clocks(5);
    check("b_pause_hold", count_b, 1);
    send_b(START);
    check("b_resume_edge", count_b, 1);
    clocks(1);
    check("b_resume_1", count_b, 1);
    clocks(1);
    check("b_resume_2", count_b, 2);
    clocks(3);
    check("b_resume_5", count_b, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
